// File: rtl/accu_avg_buffer_if.sv
// Valid/ready bundle between the accumulator, the averaging buffer and its consumer.
// The slave side is the buffer; the master side drives sums in and acknowledges heads.
interface accu_avg_buffer_if;
   logic [9:0] sum_in;
   logic       sum_valid;
   logic       out_ready;
   logic       out_valid;
   logic [9:0] sum_out;
   logic [7:0] avg_out;

   modport slave (
      input  sum_in,
      input  sum_valid,
      input  out_ready,
      output out_valid,
      output sum_out,
      output avg_out
   );

   modport master (
      output sum_in,
      output sum_valid,
      output out_ready,
      input  out_valid,
      input  sum_out,
      input  avg_out
   );
endinterface

// File: rtl/accu_avg_buffer.sv
// First-word-fall-through FIFO of 4-sample group sums with rounded average output.
// Absorbs sums from the non-stallable accumulator and counts the ones lost when full.
module accu_avg_buffer #(
   parameter int DEPTH  = 4,
   parameter int AW     = 2,
   parameter int DROP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   accu_avg_buffer_if.slave  bus,
   output logic [AW:0]       level,
   output logic              full,
   output logic              empty,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [9:0]        mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       level_q;
   logic [DROP_W-1:0] drop_q;
   logic              pop;
   logic              push;
   logic              drop;
   logic [9:0]        head_sum;

   // Status is derived from the registered level only, so it never depends on inputs.
   assign empty = (level_q == '0);
   assign full  = (level_q == FULL_LEVEL);
   assign level = level_q;
   assign drop_cnt = drop_q;

   assign bus.out_valid = !empty;

   // A full FIFO still accepts a sum when the head leaves in the same cycle.
   assign pop  = bus.out_valid && bus.out_ready;
   assign push = bus.sum_valid && (!full || pop);
   assign drop = bus.sum_valid && full && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage has no reset; the pointers and level alone decide what is valid.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= bus.sum_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= '0;
      end else if (drop && (drop_q != {DROP_W{1'b1}})) begin
         drop_q <= drop_q + 1'b1;
      end
   end

   // Data outputs read zero whenever nothing is stored.
   assign head_sum    = bus.out_valid ? mem[rd_ptr] : 10'd0;
   assign bus.sum_out = head_sum;
   assign bus.avg_out = 8'(({1'b0, head_sum} + 11'd2) >> 2);

endmodule

// File: tb/tb_accu_avg_buffer.sv
// Directed bench for accu_avg_buffer: reset, rounding, fill/drop, push-at-full,
// back-pressure hold, drop saturation and mid-run reset.
module tb_accu_avg_buffer;

   logic       clk;
   logic       rst;
   logic [2:0] level;
   logic       full;
   logic       empty;
   logic [7:0] drop_cnt;
   int         check_count;
   int         error_count;

   accu_avg_buffer_if bus ();

   accu_avg_buffer #(
      .DEPTH  (4),
      .AW     (2),
      .DROP_W (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .level    (level),
      .full     (full),
      .empty    (empty),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      check_count++;
      if (actual != expected) begin
         error_count++;
         $display("[TB] FAIL %s got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs and land 1 time unit after the capturing edge.
   task automatic applyStimulus(input logic valid, input logic [9:0] value, input logic ready);
      bus.sum_valid = valid;
      bus.sum_in    = value;
      bus.out_ready = ready;
      @(posedge clk);
      #1;
   endtask

   task automatic checkHead(input string tag, input int sum, input int avg);
      checkOutput({tag, "_valid"}, int'(bus.out_valid), 1);
      checkOutput({tag, "_sum"}, int'(bus.sum_out), sum);
      checkOutput({tag, "_avg"}, int'(bus.avg_out), avg);
   endtask

   task automatic checkEmpty(input string tag);
      checkOutput({tag, "_valid"}, int'(bus.out_valid), 0);
      checkOutput({tag, "_empty"}, int'(empty), 1);
      checkOutput({tag, "_level"}, int'(level), 0);
      checkOutput({tag, "_sum"}, int'(bus.sum_out), 0);
      checkOutput({tag, "_avg"}, int'(bus.avg_out), 0);
   endtask

   initial begin
      int tail_heads [3];

      check_count   = 0;
      error_count   = 0;
      rst           = 1'b1;
      bus.sum_valid = 1'b0;
      bus.sum_in    = 10'd0;
      bus.out_ready = 1'b0;

      // Reset for two cycles while a sum arrives; it must not be stored.
      applyStimulus(1'b1, 10'd99, 1'b0);
      applyStimulus(1'b1, 10'd99, 1'b0);
      rst = 1'b0;
      checkEmpty("reset");
      checkOutput("reset_full", int'(full), 0);
      checkOutput("reset_drop", int'(drop_cnt), 0);
      applyStimulus(1'b0, 10'd0, 1'b0);
      checkEmpty("reset_idle");

      // Largest possible sum shows up the cycle after the push.
      applyStimulus(1'b1, 10'd1020, 1'b0);
      checkHead("max", 1020, 255);
      checkOutput("max_level", int'(level), 1);
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkEmpty("max_pop");

      // Rounding: 5->1, 6->2, 9->2, each head valid for one cycle.
      applyStimulus(1'b1, 10'd5, 1'b1);
      checkHead("round5", 5, 1);
      checkOutput("round5_level", int'(level), 1);
      applyStimulus(1'b1, 10'd6, 1'b1);
      checkHead("round6", 6, 2);
      checkOutput("round6_level", int'(level), 1);
      applyStimulus(1'b1, 10'd9, 1'b1);
      checkHead("round9", 9, 2);
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkEmpty("round_done");

      // Fill, then two sums that must be dropped.
      for (int v = 1; v <= 4; v++) applyStimulus(1'b1, 10'(v), 1'b0);
      checkOutput("fill_full", int'(full), 1);
      checkOutput("fill_level", int'(level), 4);
      applyStimulus(1'b1, 10'd5, 1'b0);
      applyStimulus(1'b1, 10'd6, 1'b0);
      checkOutput("drop_cnt2", int'(drop_cnt), 2);
      checkOutput("drop_level", int'(level), 4);
      for (int v = 1; v <= 4; v++) begin
         checkOutput("drain_sum", int'(bus.sum_out), v);
         applyStimulus(1'b0, 10'd0, 1'b1);
      end
      checkEmpty("drain_done");
      checkOutput("drain_full", int'(full), 0);

      // Push and pop together while full: no drop, level stays 4.
      for (int v = 1; v <= 4; v++) applyStimulus(1'b1, 10'(v), 1'b0);
      applyStimulus(1'b1, 10'd7, 1'b1);
      checkOutput("pp_level", int'(level), 4);
      checkOutput("pp_drop", int'(drop_cnt), 2);
      checkOutput("pp_head", int'(bus.sum_out), 2);
      tail_heads[0] = 3;
      tail_heads[1] = 4;
      tail_heads[2] = 7;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 10'd0, 1'b1);
         checkOutput("pp_next", int'(bus.sum_out), tail_heads[i]);
      end
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkEmpty("pp_done");

      // Head must hold still under back-pressure.
      applyStimulus(1'b1, 10'd300, 1'b0);
      applyStimulus(1'b1, 10'd400, 1'b0);
      checkOutput("bp_level", int'(level), 2);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 10'd0, 1'b0);
         checkHead("bp_hold", 300, 75);
      end
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkOutput("bp_pop_level", int'(level), 1);
      checkHead("bp_next", 400, 100);
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkEmpty("bp_done");

      // Drop counter saturates; the stored entries are untouched.
      for (int v = 11; v <= 14; v++) applyStimulus(1'b1, 10'(v), 1'b0);
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, 10'd99, 1'b0);
      checkOutput("sat_drop", int'(drop_cnt), 255);
      checkOutput("sat_level", int'(level), 4);
      checkHead("sat_head", 11, 3);
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkOutput("sat_pop_level", int'(level), 3);
      checkOutput("sat_pop_head", int'(bus.sum_out), 12);

      // Reset with three entries stored and a coincident sum.
      rst = 1'b1;
      applyStimulus(1'b1, 10'd500, 1'b0);
      rst = 1'b0;
      checkEmpty("midrst");
      checkOutput("midrst_drop", int'(drop_cnt), 0);
      checkOutput("midrst_full", int'(full), 0);
      applyStimulus(1'b0, 10'd0, 1'b0);
      checkEmpty("midrst_idle");

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
